psum_accum_buffer: RTL
======================

Name: psum_accum_buffer

Overview:
- Sits directly downstream of the PE array's bottom-row psum outputs.
- Captures per-column partial sums (psum_valid/psum_addr/psum) and accumulates them across weight passes into per-column banks.
- When the controller requests it, drains the final results column-major through a valid/ready stream to the output writer.
- Reports busy/done/err to the controller.

Parameters:
NUM_COLS, 3, number of PE-array columns (one bank each)
PSUM_W, 32, signed width of incoming psums
ACC_W, 40, signed accumulator/output width (ACC_W >= PSUM_W)
DEPTH, 16, entries per bank; AW = $clog2(DEPTH)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: clear all entry-valid flags, enter ACCUM
psum_valid  in  NUM_COLS  per-column psum strobe
psum_addr  in  NUM_COLS x AW  per-column target entry
psum  in  NUM_COLS x PSUM_W  per-column signed psum
drain_req  in  1  single-cycle pulse: accumulation finished, begin drain
out_valid  out  1  drain data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  ACC_W  accumulated value
out_col  out  $clog2(NUM_COLS)  column of out_data
out_addr  out  AW  entry of out_data
busy  out  1  high in ACCUM or DRAIN
done  out  1  one-cycle pulse after last drain handshake
err  out  1  sticky protocol error, cleared by start

Behaviour:
- Reset (rstn low, async): state IDLE; out_valid, busy, done, err = 0; out_data/out_col/out_addr = 0; all entry-valid flags cleared. Bank contents are don't-care.
- States and transitions:
  - IDLE: start -> ACCUM.
  - ACCUM: drain_req -> DRAIN, once all in-flight writes have retired (at most 2 cycles).
  - DRAIN: last handshake (col NUM_COLS-1, addr DEPTH-1) -> DONE.
  - DONE: returns to IDLE next cycle; done = 1 for exactly that one cycle.
  - start in any state: clears flags and err, aborts any drain (out_valid drops next cycle), enters ACCUM.
- Accumulate, ACCUM only, per column independent:
  - Each cycle a column may present one psum.
  - Stage 1 registers addr/psum and reads the bank plus the entry-valid flag.
  - Stage 2 writes: sum = (flag ? stored : 0) + sign-extended psum, saturated to the signed ACC_W range; flag is set.
  - Back-to-back writes to the same address (cycle n, n+1) forward the stage-2 result into stage 1; no lost update.
  - Latency psum_valid -> bank updated: 2 cycles.
- Arithmetic: signed two's complement. Saturate to +2^(ACC_W-1)-1 / -2^(ACC_W-1). Saturation is not an error.
- Error conditions (set err; the input is otherwise ignored):
  - psum_valid while not in ACCUM;
  - psum_addr >= DEPTH when DEPTH is not a power of 2;
  - drain_req while not in ACCUM.
- Drain:
  - Order: column-major, col 0 addr 0..DEPTH-1, then col 1, and so on.
  - Read latency is hidden with a 1-entry skid/prefetch, so a full-throughput drain (out_ready held high) gives one word per cycle after an initial 2-cycle fill.
  - Entries whose flag is clear output 0.
  - out_data/out_col/out_addr hold stable while out_valid & !out_ready.
  - out_valid never drops without a handshake, except on start or reset.
- Simultaneous events:
  - start and drain_req in the same cycle: start wins.
  - psum_valid in the same cycle as drain_req: the psum is accepted and retired before DRAIN is entered.

Decomposition:
- Shared package ws_pkg: NUM_COLS, PSUM_W, ACC_W, DEPTH defaults; the state enum (IDLE/ACCUM/DRAIN/DONE); the function sat_add(stored, psum) returning a saturated ACC_W result.
- Sub-module psum_bank, instantiated NUM_COLS times. Each instance holds the RAM, the entry-valid flags, the 2-stage read-modify-write with forwarding, and a drain read port (the drain read is muxed onto the same read port; accumulation and drain never overlap).
- The top holds the FSM, the drain address counters, the output skid register and err/done.

Test Plan:
- Single pass: start; col0 addr 3 gets psum 5, col2 addr 0 gets psum -7; drain_req; out_ready held 1 -> 48 words in order; (0,3)=5, (2,0)=-7, all others 0; done pulses once; busy falls with done.
- Multi-pass with forwarding: col1 addr 2 gets psums 10, 20, 30 on consecutive cycles, plus col1 addr 5 gets 4 twice separated by 3 idle cycles -> drain gives (1,2)=60 and (1,5)=8.
- Saturation: ACC_W=40; col0 addr 0 receives 0x7FFFFFFF 300 times -> output 0x7FFFFFFFFF. The negative case with 0x80000000 -> -2^39.
- Backpressure: during drain, toggle out_ready pseudo-randomly (about 50%) -> all 48 words delivered exactly once, in order; fields stable during stalls; no word dropped or duplicated.
- Protocol errors: psum_valid in IDLE -> err=1, banks untouched. Then start -> err=0. drain_req in DRAIN -> err=1, drain continues unaffected.
- Reset/abort: assert rstn low mid-drain after 10 words -> all outputs 0 immediately. Separately, start mid-drain -> out_valid=0 next cycle, state ACCUM, subsequent drain yields all zeros.

Source files
------------

// File: rtl/ws_pkg.sv
// Shared definitions for the psum accumulation buffer.
// Holds the default geometry, the controller-facing state encoding and the
// saturating accumulate used by every column bank.
package ws_pkg;

  localparam int WS_NUM_COLS = 3;
  localparam int WS_PSUM_W   = 32;
  localparam int WS_ACC_W    = 40;
  localparam int WS_DEPTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One extra bit of headroom shows overflow: if the top two bits of the
  // widened sum disagree, the true result left the signed ACC_W range and we
  // clamp towards the side indicated by the sign of the wide sum.
  function automatic logic signed [WS_ACC_W-1:0] sat_add(
    input logic signed [WS_ACC_W-1:0]  stored,
    input logic signed [WS_PSUM_W-1:0] psum
  );
    logic signed [WS_ACC_W:0] sum;
    sum = {stored[WS_ACC_W-1], stored} +
          {{(WS_ACC_W - WS_PSUM_W + 1){psum[WS_PSUM_W-1]}}, psum};
    if (sum[WS_ACC_W] != sum[WS_ACC_W-1]) begin
      if (sum[WS_ACC_W]) return {1'b1, {(WS_ACC_W-1){1'b0}}};
      else               return {1'b0, {(WS_ACC_W-1){1'b1}}};
    end
    return sum[WS_ACC_W-1:0];
  endfunction

endpackage

// File: rtl/psum_bank.sv
// One column's accumulation bank.
// Holds the entry storage, per-entry valid flags and a two-stage
// read-modify-write pipeline. The single read port serves both accumulation
// (read-before-add) and draining; the two uses never overlap in time.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   clear_i         clear all entry flags and kill the in-flight write
//   acc_valid_i     accept psum_i for entry rd_addr_i into the pipeline
//   rd_en_i         perform a read of rd_addr_i this cycle
//   rd_addr_i       entry to read (accumulate target or drain address)
//   psum_i          signed partial sum to accumulate
//   rd_data_o       last read result, 0 if the entry's flag was clear
module psum_bank
  import ws_pkg::*;
#(
  parameter int PSUM_W = WS_PSUM_W,
  parameter int ACC_W  = WS_ACC_W,
  parameter int DEPTH  = WS_DEPTH,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              acc_valid_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [PSUM_W-1:0] psum_i,
  output logic [ACC_W-1:0]  rd_data_o
);

  logic [ACC_W-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  flag_q;
  logic              s1_valid_q;
  logic [AW-1:0]     s1_addr_q;
  logic [PSUM_W-1:0] s1_psum_q;
  logic [ACC_W-1:0]  rd_data_q;
  logic              rd_flag_q;
  logic [ACC_W-1:0]  sum_d;
  logic              fwd;

  // Stage 2 adds the psum onto whatever stage 1 fetched. A read of the
  // address being written this very cycle would see the stale RAM word, so
  // it takes the freshly computed sum instead.
  always_comb begin
    sum_d = sat_add(rd_flag_q ? rd_data_q : '0, s1_psum_q);
    fwd   = s1_valid_q && (s1_addr_q == rd_addr_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      flag_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
      rd_data_q  <= '0;
      rd_flag_q  <= 1'b0;
    end else if (clear_i) begin
      flag_q     <= '0;
      s1_valid_q <= 1'b0;
      rd_flag_q  <= 1'b0;
    end else begin
      s1_valid_q <= acc_valid_i;
      if (acc_valid_i) begin
        s1_addr_q <= rd_addr_i;
        s1_psum_q <= psum_i;
      end
      if (s1_valid_q) flag_q[s1_addr_q] <= 1'b1;
      if (rd_en_i) begin
        if (fwd) begin
          rd_data_q <= sum_d;
          rd_flag_q <= 1'b1;
        end else begin
          rd_data_q <= mem_q[rd_addr_i];
          rd_flag_q <= flag_q[rd_addr_i];
        end
      end
    end
  end

  // Storage has no reset; the flags decide whether a word is meaningful.
  always_ff @(posedge clk_i) begin
    if (s1_valid_q) mem_q[s1_addr_q] <= sum_d;
  end

  assign rd_data_o = rd_flag_q ? rd_data_q : '0;

endmodule

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer below the PE array.
// Accumulates per-column psums across weight passes into one bank per column,
// then drains every entry column-major over a valid/ready stream.
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   start                       clear flags/err, (re)enter accumulation
//   psum_valid/psum_addr/psum   per-column psum strobe, entry and value
//   drain_req                   accumulation finished, begin draining
//   out_valid/out_ready         drain stream handshake
//   out_data/out_col/out_addr   drained value and its location
//   busy, done, err             status towards the controller
module psum_accum_buffer
  import ws_pkg::*;
#(
  parameter int NUM_COLS = WS_NUM_COLS,
  parameter int PSUM_W   = WS_PSUM_W,
  parameter int ACC_W    = WS_ACC_W,
  parameter int DEPTH    = WS_DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [NUM_COLS-1:0]              psum_valid,
  input  logic [NUM_COLS-1:0][AW-1:0]      psum_addr,
  input  logic [NUM_COLS-1:0][PSUM_W-1:0]  psum,
  input  logic                             drain_req,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic [CW-1:0]                    out_col,
  output logic [AW-1:0]                    out_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam logic [CW-1:0] LAST_COL   = CW'(NUM_COLS - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam bit            DEPTH_POW2 = ((DEPTH & (DEPTH - 1)) == 0);

  state_e            state_q;
  logic              pend_q;
  logic [CW-1:0]     iss_col_q;
  logic [AW-1:0]     iss_addr_q;
  logic              iss_left_q;
  logic              f_valid_q;
  logic [CW-1:0]     f_col_q;
  logic [AW-1:0]     f_addr_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_data_q;
  logic [CW-1:0]     out_col_q;
  logic [AW-1:0]     out_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [NUM_COLS-1:0] in_range;
  logic [NUM_COLS-1:0] acc_en;
  logic [NUM_COLS-1:0] bank_rd_en;
  logic [ACC_W-1:0]    bank_data [NUM_COLS];
  logic                accepting;
  logic                proto_err;
  logic                out_load;
  logic                issue;
  logic                last_hs;

  // Psums are only taken in ACCUM before a drain request is pending, so the
  // last accepted write always retires before DRAIN begins reading.
  // The fetch slot (f_*) is a one-entry prefetch: a new drain read is only
  // issued when that slot will be free next cycle, which keeps the bank's
  // read register stable for as long as the output is stalled.
  always_comb begin
    accepting = (state_q == ACCUM) && !pend_q && !start;
    for (int c = 0; c < NUM_COLS; c++) begin
      in_range[c] = DEPTH_POW2 || (int'(psum_addr[c]) < DEPTH);
      acc_en[c]   = accepting && psum_valid[c] && in_range[c];
    end
    proto_err = ((|psum_valid) && !accepting)
             || (|(psum_valid & ~in_range))
             || (drain_req && (state_q != ACCUM));
    out_load  = f_valid_q && (!out_valid_q || out_ready);
    issue     = (state_q == DRAIN) && iss_left_q && (!f_valid_q || out_load);
    last_hs   = out_valid_q && out_ready &&
                (out_col_q == LAST_COL) && (out_addr_q == LAST_ADDR);
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_bank
    assign bank_rd_en[c] = acc_en[c] || (issue && (iss_col_q == CW'(c)));

    psum_bank #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .clear_i     (start),
      .acc_valid_i (acc_en[c]),
      .rd_en_i     (bank_rd_en[c]),
      .rd_addr_i   ((state_q == DRAIN) ? iss_addr_q : psum_addr[c]),
      .psum_i      (psum[c]),
      .rd_data_o   (bank_data[c])
    );
  end

  // Control FSM, drain counters, output register and status flags.
  // start overrides everything else, including a drain_req in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      iss_col_q   <= '0;
      iss_addr_q  <= '0;
      iss_left_q  <= 1'b0;
      f_valid_q   <= 1'b0;
      f_col_q     <= '0;
      f_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (start) begin
      state_q     <= ACCUM;
      pend_q      <= 1'b0;
      iss_col_q   <= '0;
      iss_addr_q  <= '0;
      iss_left_q  <= 1'b0;
      f_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (proto_err) err_q <= 1'b1;
      case (state_q)
        IDLE: ;
        ACCUM: begin
          if (pend_q) begin
            state_q    <= DRAIN;
            pend_q     <= 1'b0;
            iss_col_q  <= '0;
            iss_addr_q <= '0;
            iss_left_q <= 1'b1;
          end else if (drain_req) begin
            pend_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (issue) begin
            f_valid_q <= 1'b1;
            f_col_q   <= iss_col_q;
            f_addr_q  <= iss_addr_q;
            if (iss_addr_q == LAST_ADDR) begin
              iss_addr_q <= '0;
              if (iss_col_q == LAST_COL) iss_left_q <= 1'b0;
              else                       iss_col_q  <= iss_col_q + CW'(1);
            end else begin
              iss_addr_q <= iss_addr_q + AW'(1);
            end
          end else if (out_load) begin
            f_valid_q <= 1'b0;
          end
          if (out_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bank_data[f_col_q];
            out_col_q   <= f_col_q;
            out_addr_q  <= f_addr_q;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (last_hs) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
